// File: rtl/pcileech_ft601_peer_pkg.sv
// Shared types for the FT601 peer model: pacing FSM states and err_flags bit positions.
package pcileech_ft601_peer_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_BURST, RX_GAP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_BURST, TX_GAP} tx_state_t;

    localparam int ERR_RD_NOT_READY = 0;
    localparam int ERR_WR_NOT_READY = 1;
    localparam int ERR_WR_OE        = 2;
    localparam int ERR_WR_DROP      = 3;

endpackage

// File: rtl/pcileech_ft601_peer_fifo.sv
// Sync FIFO with show-ahead head (0 when empty), count, full/empty.
// Head is visible the cycle after a push; a push while full is taken only if a pop frees the slot.
module pcileech_ft601_peer_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int CW      = DEPTH_LOG2 + 1;
    localparam int DEPTH_N = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH = CW'(DEPTH_N);

    logic [WIDTH-1:0]      mem [DEPTH_N];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pcileech_ft601_peer.sv
// FT601 chip-side model of the 245 sync FIFO bus, buffering host streams to/from the FPGA.
// rxf_n/txe_n are paced into bursts with gaps; host_tx_ready drops when RX is full, FPGA writes beyond TX capacity are dropped.
module pcileech_ft601_peer
    import pcileech_ft601_peer_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 6,
    parameter int TX_DEPTH_LOG2 = 6,
    parameter int BURST_WORDS   = 1024,
    parameter int GAP_CYCLES    = 4,
    parameter int TXE_MARGIN    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] host_tx_data,
    input  logic        host_tx_valid,
    output logic        host_tx_ready,
    output logic [31:0] host_rx_data,
    output logic [3:0]  host_rx_be,
    output logic        host_rx_valid,
    input  logic        host_rx_ready,
    output logic [31:0] ft601_data_o,
    input  logic [31:0] ft601_data_i,
    input  logic [3:0]  ft601_be_i,
    output logic        ft601_rxf_n,
    output logic        ft601_txe_n,
    input  logic        ft601_rd_n,
    input  logic        ft601_oe_n,
    input  logic        ft601_wr_n,
    input  logic        ft601_siwu_n,
    output logic [3:0]  err_flags
);
    localparam int RXC = RX_DEPTH_LOG2 + 1;
    localparam int TXC = TX_DEPTH_LOG2 + 1;
    localparam int BW  = $clog2(BURST_WORDS) + 1;
    localparam int GW  = $clog2(GAP_CYCLES) + 1;
    localparam logic [BW-1:0]  BURST_LIMIT = BW'(BURST_WORDS);
    localparam logic [GW-1:0]  GAP_LAST    = GW'(GAP_CYCLES - 1);
    localparam logic [TXC-1:0] TX_DEPTH    = TXC'(1 << TX_DEPTH_LOG2);
    localparam logic [TXC-1:0] MARGIN      = TXC'(TXE_MARGIN);

    logic [31:0]    rx_head;
    logic [RXC-1:0] rx_count;
    logic [RXC-1:0] rx_count_nxt;
    logic           rx_full, rx_empty, rx_push, rx_pop, rx_avail;
    rx_state_t      rx_state;
    logic [BW-1:0]  rx_burst_cnt;
    logic [GW-1:0]  rx_gap_cnt;

    logic [35:0]    tx_head;
    logic [TXC-1:0] tx_count, tx_count_nxt, tx_free, tx_free_nxt;
    logic           tx_full, tx_empty, tx_push, tx_pop, tx_wr, tx_vld_q;
    tx_state_t      tx_state;
    logic [BW-1:0]  tx_burst_cnt;
    logic [GW-1:0]  tx_gap_cnt;

    logic           ready_en, oe_q;
    logic [3:0]     err_new;
    logic           unused_siwu;

    assign unused_siwu = ft601_siwu_n;

    assign host_tx_ready = ready_en & ~rx_full;
    assign rx_push       = host_tx_valid & host_tx_ready;
    assign rx_pop        = ~ft601_rd_n & ~ft601_oe_n & ~ft601_rxf_n & ~rx_empty;
    assign rx_count_nxt  = rx_count + RXC'(rx_push) - RXC'(rx_pop);
    assign ft601_data_o  = oe_q ? rx_head : '0;

    assign tx_pop        = host_rx_valid & host_rx_ready;
    assign tx_push       = ~ft601_wr_n & (~tx_full | tx_pop);
    assign tx_wr         = ~ft601_wr_n & ~ft601_txe_n;
    assign tx_count_nxt  = tx_count + TXC'(tx_push) - TXC'(tx_pop);
    assign tx_free       = TX_DEPTH - tx_count;
    assign tx_free_nxt   = TX_DEPTH - tx_count_nxt;
    assign host_rx_valid = tx_vld_q & ~tx_empty;
    assign host_rx_data  = tx_head[31:0];
    assign host_rx_be    = tx_head[35:32];

    pcileech_ft601_peer_fifo #(.WIDTH(32), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (host_tx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    pcileech_ft601_peer_fifo #(.WIDTH(36), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data ({ft601_be_i, ft601_data_i}),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_comb begin
        err_new                   = '0;
        err_new[ERR_RD_NOT_READY] = ~ft601_rd_n & ft601_rxf_n;
        err_new[ERR_WR_NOT_READY] = ~ft601_wr_n & ft601_txe_n;
        err_new[ERR_WR_OE]        = ~ft601_wr_n & ~ft601_oe_n;
        err_new[ERR_WR_DROP]      = ~ft601_wr_n & tx_full & ~tx_pop;
    end

    // rx_avail and tx_vld_q add the one-cycle delay seen by the FPGA and host on fresh data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            oe_q      <= 1'b0;
            rx_avail  <= 1'b0;
            tx_vld_q  <= 1'b0;
            err_flags <= '0;
        end else begin
            ready_en  <= 1'b1;
            oe_q      <= ~ft601_oe_n;
            rx_avail  <= ~rx_empty;
            tx_vld_q  <= ~tx_empty;
            err_flags <= err_flags | err_new;
        end
    end

    // Gap counter starts at 1 so the flag stays high GAP_CYCLES cycles in total, IDLE included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= RX_IDLE;
            ft601_rxf_n  <= 1'b1;
            rx_burst_cnt <= '0;
            rx_gap_cnt   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_avail) begin
                        rx_state     <= RX_BURST;
                        ft601_rxf_n  <= 1'b0;
                        rx_burst_cnt <= '0;
                    end
                end
                RX_BURST: begin
                    if (rx_pop) rx_burst_cnt <= rx_burst_cnt + BW'(1);
                    if (rx_count_nxt == '0 ||
                        (rx_pop && (rx_burst_cnt + BW'(1) == BURST_LIMIT))) begin
                        rx_state    <= RX_GAP;
                        ft601_rxf_n <= 1'b1;
                        rx_gap_cnt  <= GW'(1);
                    end
                end
                RX_GAP: begin
                    if (rx_gap_cnt >= GAP_LAST) rx_state <= RX_IDLE;
                    else                        rx_gap_cnt <= rx_gap_cnt + GW'(1);
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state     <= TX_IDLE;
            ft601_txe_n  <= 1'b1;
            tx_burst_cnt <= '0;
            tx_gap_cnt   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_free > MARGIN) begin
                        tx_state     <= TX_BURST;
                        ft601_txe_n  <= 1'b0;
                        tx_burst_cnt <= '0;
                    end
                end
                TX_BURST: begin
                    if (tx_wr) tx_burst_cnt <= tx_burst_cnt + BW'(1);
                    if (tx_free_nxt <= MARGIN ||
                        (tx_wr && (tx_burst_cnt + BW'(1) == BURST_LIMIT))) begin
                        tx_state    <= TX_GAP;
                        ft601_txe_n <= 1'b1;
                        tx_gap_cnt  <= GW'(1);
                    end
                end
                TX_GAP: begin
                    if (tx_gap_cnt >= GAP_LAST) tx_state <= TX_IDLE;
                    else                        tx_gap_cnt <= tx_gap_cnt + GW'(1);
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_ft601_peer.sv
// Directed bench for pcileech_ft601_peer: default instance plus a BURST_WORDS=8 instance for burst pacing.
module tb_pcileech_ft601_peer;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [31:0] host_tx_data, host_rx_data, ft601_data_o, ft601_data_i;
    logic        host_tx_valid, host_tx_ready, host_rx_valid, host_rx_ready;
    logic [3:0]  host_rx_be, ft601_be_i, err_flags;
    logic        ft601_rxf_n, ft601_txe_n, ft601_rd_n, ft601_oe_n, ft601_wr_n, ft601_siwu_n;

    logic [31:0] b_host_tx_data, b_host_rx_data, b_data_o;
    logic        b_host_tx_valid, b_host_tx_ready, b_host_rx_valid;
    logic [3:0]  b_host_rx_be, b_err_flags;
    logic        b_rxf_n, b_txe_n, b_rd_n, b_oe_n;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops, hi, gaps;
    logic [35:0] exp36;

    pcileech_ft601_peer u_dut (
        .clk(clk), .rst_n(rst_n),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_be(host_rx_be), .host_rx_valid(host_rx_valid),
        .host_rx_ready(host_rx_ready), .ft601_data_o(ft601_data_o), .ft601_data_i(ft601_data_i),
        .ft601_be_i(ft601_be_i), .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
        .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n), .ft601_wr_n(ft601_wr_n),
        .ft601_siwu_n(ft601_siwu_n), .err_flags(err_flags)
    );

    pcileech_ft601_peer #(.BURST_WORDS(8)) u_dut_b8 (
        .clk(clk), .rst_n(rst_n),
        .host_tx_data(b_host_tx_data), .host_tx_valid(b_host_tx_valid), .host_tx_ready(b_host_tx_ready),
        .host_rx_data(b_host_rx_data), .host_rx_be(b_host_rx_be), .host_rx_valid(b_host_rx_valid),
        .host_rx_ready(1'b0), .ft601_data_o(b_data_o), .ft601_data_i(32'h0),
        .ft601_be_i(4'h0), .ft601_rxf_n(b_rxf_n), .ft601_txe_n(b_txe_n),
        .ft601_rd_n(b_rd_n), .ft601_oe_n(b_oe_n), .ft601_wr_n(1'b1),
        .ft601_siwu_n(1'b1), .err_flags(b_err_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        host_tx_data = '0; host_tx_valid = 1'b0; host_rx_ready = 1'b0;
        ft601_data_i = '0; ft601_be_i = '0;
        ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; ft601_wr_n = 1'b1; ft601_siwu_n = 1'b1;
        b_host_tx_data = '0; b_host_tx_valid = 1'b0; b_rd_n = 1'b1; b_oe_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_rxf_n", ft601_rxf_n, 1);
        check("rst_txe_n", ft601_txe_n, 1);
        check("rst_data_o", ft601_data_o, 0);
        check("rst_tx_ready", host_tx_ready, 0);
        check("rst_rx_valid", host_rx_valid, 0);
        check("rst_rx_data", host_rx_data, 0);
        check("rst_rx_be", host_rx_be, 0);
        check("rst_err", err_flags, 0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", host_tx_ready, 0);
        @(negedge clk);
        check("ready_after_edge", host_tx_ready, 1);

        // Four words, then the FPGA reads them back
        host_tx_valid = 1'b1; host_tx_data = 32'hA5A5_0001;
        @(negedge clk); host_tx_data = 32'hA5A5_0002;
        @(negedge clk); check("rxf_n_at_n1", ft601_rxf_n, 1); host_tx_data = 32'hA5A5_0003;
        @(negedge clk); check("rxf_n_at_n2", ft601_rxf_n, 0); host_tx_data = 32'hA5A5_0004;
        @(negedge clk); host_tx_valid = 1'b0;
        ft601_oe_n = 1'b0;
        @(negedge clk);
        check("t1_first_word", ft601_data_o, 32'hA5A5_0001);
        for (int k = 0; k < 4; k++) begin
            ft601_rd_n = 1'b0;
            check("t1_word", ft601_data_o, 32'hA5A5_0001 + k);
            check("t1_rxf_low", ft601_rxf_n, 0);
            @(negedge clk);
        end
        check("t1_rxf_after_last", ft601_rxf_n, 1);
        ft601_rd_n = 1'b1; ft601_oe_n = 1'b1;
        check("t1_no_err", err_flags, 0);

        // Burst pacing on the BURST_WORDS=8 instance
        b_host_tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b_host_tx_data = 32'hB000_0000 + i;
            @(negedge clk);
        end
        b_host_tx_valid = 1'b0;
        b_oe_n = 1'b0;
        pops = 0; hi = 0; gaps = 0;
        for (int c = 0; c < 300 && pops < 20; c++) begin
            @(negedge clk);
            if (!b_rxf_n) begin
                if (hi != 0) begin
                    check("t2_gap_len", hi, 4);
                    hi = 0;
                end
                check("t2_data", b_data_o, 32'hB000_0000 + pops);
                b_rd_n = 1'b0;
                pops++;
            end else begin
                b_rd_n = 1'b1;
                if (pops != 0) begin
                    if (hi == 0) begin
                        gaps++;
                        check("t2_gap_at", pops, gaps * 8);
                    end
                    hi++;
                end
            end
        end
        @(negedge clk);
        b_rd_n = 1'b1; b_oe_n = 1'b1;
        check("t2_pops", pops, 20);
        check("t2_gaps", gaps, 2);
        check("t2_rxf_end", b_rxf_n, 1);
        check("t2_no_err", b_err_flags, 0);

        // Read attempt on an empty buffer
        check("t4_data_idle", ft601_data_o, 0);
        ft601_rd_n = 1'b0; ft601_oe_n = 1'b0;
        @(negedge clk);
        check("t4_rd_empty_err0", err_flags[0], 1);
        check("t4_rd_empty_data", ft601_data_o, 0);
        ft601_rd_n = 1'b1; ft601_oe_n = 1'b1;

        // Host push and FPGA pop together at depth 1
        host_tx_valid = 1'b1; host_tx_data = 32'hD000_0000;
        @(negedge clk); host_tx_valid = 1'b0;
        for (int c = 0; c < 20 && ft601_rxf_n; c++) @(negedge clk);
        check("t5_rxf_low", ft601_rxf_n, 0);
        ft601_oe_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            check("t5_data", ft601_data_o, 32'hD000_0000 + i);
            check("t5_rxf", ft601_rxf_n, 0);
            ft601_rd_n = 1'b0; host_tx_valid = 1'b1; host_tx_data = 32'hD000_0000 + i + 1;
            @(negedge clk);
        end
        host_tx_valid = 1'b0;
        check("t5_last", ft601_data_o, 32'hD000_0064);
        check("t5_rxf_last", ft601_rxf_n, 0);
        @(negedge clk);
        ft601_rd_n = 1'b1; ft601_oe_n = 1'b1;
        check("t5_rxf_empty", ft601_rxf_n, 1);

        // FPGA fills the TX buffer with the host stalled
        check("t3_txe_low", ft601_txe_n, 0);
        for (int i = 0; i < 65; i++) begin
            if (i == 1) check("t3_vld_n0", host_rx_valid, 0);
            if (i == 2) check("t3_vld_n1", host_rx_valid, 1);
            if (i == 59) check("t3_txe_before60", ft601_txe_n, 0);
            if (i == 60) begin
                check("t3_txe_at60", ft601_txe_n, 1);
                check("t3_err1_clear", err_flags[1], 0);
            end
            if (i == 64) begin
                check("t3_err1_set", err_flags[1], 1);
                check("t3_err3_clear", err_flags[3], 0);
            end
            ft601_wr_n = 1'b0; ft601_data_i = 32'hC000_0000 + i; ft601_be_i = 4'hF;
            @(negedge clk);
        end
        ft601_wr_n = 1'b1;
        check("t3_err3_set", err_flags[3], 1);
        check("t3_err2_clear", err_flags[2], 0);
        host_rx_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp36 = {4'hF, 32'hC000_0000 + i};
            check("t3_rx_word", {host_rx_valid, host_rx_be, host_rx_data}, {1'b1, exp36});
            @(negedge clk);
        end
        check("t3_drained", host_rx_valid, 0);

        // Write strobe with oe_n low
        ft601_wr_n = 1'b0; ft601_oe_n = 1'b0; ft601_data_i = 32'h1234_5678;
        @(negedge clk);
        ft601_wr_n = 1'b1; ft601_oe_n = 1'b1;
        check("t4_wr_oe_err2", err_flags[2], 1);
        repeat (3) @(negedge clk);
        host_rx_ready = 1'b0;

        // Reset in the middle of traffic
        host_tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_tx_data = 32'hE000_0000 + i;
            @(negedge clk);
        end
        host_tx_valid = 1'b0;
        for (int c = 0; c < 20 && ft601_rxf_n; c++) @(negedge clk);
        check("t6_rxf_low", ft601_rxf_n, 0);
        ft601_oe_n = 1'b0; ft601_rd_n = 1'b0; ft601_wr_n = 1'b0; ft601_data_i = 32'hF00D_0000;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rxf_n", ft601_rxf_n, 1);
        check("t6_rst_txe_n", ft601_txe_n, 1);
        check("t6_rst_data_o", ft601_data_o, 0);
        check("t6_rst_tx_ready", host_tx_ready, 0);
        check("t6_rst_rx_valid", host_rx_valid, 0);
        check("t6_rst_rx_data", {host_rx_be, host_rx_data}, 0);
        check("t6_rst_err", err_flags, 0);
        ft601_oe_n = 1'b1; ft601_rd_n = 1'b1; ft601_wr_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_rel_rxf_n", ft601_rxf_n, 1);
        check("t6_rel_txe_n", ft601_txe_n, 1);
        repeat (3) @(negedge clk);
        check("t6_rx_empty", ft601_rxf_n, 1);
        check("t6_tx_empty", host_rx_valid, 0);
        check("t6_txe_resumes", ft601_txe_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
